// File: rtl/life_pkg.sv
// Shared definitions for the life-grid column controller: command encodings,
// controller states and the width of one 4-cell column.
package life_pkg;

    localparam int CELL_W = 4;

    typedef enum logic [1:0] {
        OP_STEP  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_WRITE = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_LOAD,
        S_WRITE,
        S_CLEAR,
        S_DONE
    } state_e;

endpackage

// File: rtl/life_onehot.sv
// Column-index decoder: one-hot select of column idx, all zeros when disabled
// or when idx is beyond the last column.
module life_onehot #(
    parameter int NCOLS = 8
) (
    input  logic                     en,
    input  logic [$clog2(NCOLS)-1:0] idx,
    output logic [NCOLS-1:0]         onehot
);

    localparam int IW = $clog2(NCOLS);

    always_comb begin
        for (int i = 0; i < NCOLS; i++) begin
            onehot[i] = en && (idx == IW'(i));
        end
    end

endmodule

// File: rtl/life_ctrl.sv
// Life-grid column controller: accepts STEP/LOAD/WRITE/CLEAR commands and
// sequences the shared column controls; every output comes straight from a flop.
module life_ctrl
    import life_pkg::*;
#(
    parameter int NCOLS = 8,
    parameter int CW    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [CW-1:0]            cmd_count,
    input  logic [$clog2(NCOLS)-1:0] cmd_col,
    input  logic [1:0]               cmd_row,
    input  logic                     cmd_val,
    input  logic                     halt,
    input  logic [CELL_W-1:0]        ld_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    output logic [NCOLS-1:0]         col_sel,
    output logic                     enable,
    output logic                     scan,
    output logic [CELL_W-1:0]        scan_val,
    output logic                     write_enb,
    output logic [1:0]               row,
    output logic                     val,
    output logic [15:0]              gen_count,
    output logic                     done
);

    localparam int IW = $clog2(NCOLS);

    state_e            state, state_n;
    logic [CW-1:0]     left, left_n;
    logic [IW-1:0]     col_idx, idx_n;
    logic              drain, drain_n;

    logic              ready_n, ld_ready_n, enable_n, scan_n, write_n, val_n, done_n;
    logic [CELL_W-1:0] scan_val_n;
    logic [1:0]        row_n;
    logic [15:0]       gen_n;
    logic [NCOLS-1:0]  col_sel_n;

    logic              oh_en, all_cols;
    logic [IW-1:0]     oh_idx;
    logic [NCOLS-1:0]  oh_cols;
    op_e               op;

    assign op = op_e'(cmd_op);

    life_onehot #(.NCOLS(NCOLS)) u_onehot (
        .en     (oh_en),
        .idx    (oh_idx),
        .onehot (oh_cols)
    );

    // Outputs are computed for the state being entered and then registered,
    // so each control is high exactly during the cycles of that state.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_n    = state;
        left_n     = left;
        idx_n      = col_idx;
        drain_n    = drain;
        gen_n      = gen_count;
        scan_n     = 1'b0;
        scan_val_n = '0;
        write_n    = 1'b0;
        row_n      = '0;
        val_n      = 1'b0;
        oh_en      = 1'b0;
        oh_idx     = col_idx;
        all_cols   = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    unique case (op)
                        OP_STEP: begin
                            left_n  = cmd_count;
                            state_n = (cmd_count == '0) ? S_DONE : S_STEP;
                        end
                        OP_LOAD: begin
                            idx_n   = '0;
                            drain_n = 1'b0;
                            state_n = S_LOAD;
                        end
                        OP_WRITE: begin
                            oh_en   = 1'b1;
                            oh_idx  = cmd_col;
                            row_n   = cmd_row;
                            val_n   = cmd_val;
                            write_n = 1'b1;
                            state_n = S_WRITE;
                        end
                        OP_CLEAR: begin
                            scan_n   = 1'b1;
                            all_cols = 1'b1;
                            state_n  = S_CLEAR;
                        end
                    endcase
                end
            end
            S_STEP: begin
                left_n = left - CW'(1);
                if (halt || left == CW'(1)) state_n = S_DONE;
            end
            S_LOAD: begin
                // The cycle after the final beat drains its scan pulse before DONE.
                if (drain) begin
                    state_n = S_DONE;
                end else if (ld_valid) begin
                    scan_n     = 1'b1;
                    scan_val_n = ld_data;
                    oh_en      = 1'b1;
                    if (col_idx == IW'(NCOLS - 1)) begin
                        drain_n = 1'b1;
                        idx_n   = '0;
                    end else begin
                        idx_n = col_idx + IW'(1);
                    end
                end
            end
            S_WRITE, S_CLEAR: state_n = S_DONE;
            S_DONE:           state_n = S_IDLE;
            default:          state_n = S_IDLE;
        endcase

        enable_n   = (state_n == S_STEP);
        ready_n    = (state_n == S_IDLE);
        ld_ready_n = (state_n == S_LOAD) && !drain_n;
        done_n     = (state_n == S_DONE);
        col_sel_n  = all_cols ? '1 : oh_cols;
        if (enable_n) gen_n = gen_count + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state     <= S_IDLE;
            left      <= '0;
            col_idx   <= '0;
            drain     <= 1'b0;
            cmd_ready <= 1'b1;
            ld_ready  <= 1'b0;
            col_sel   <= '0;
            enable    <= 1'b0;
            scan      <= 1'b0;
            scan_val  <= '0;
            write_enb <= 1'b0;
            row       <= '0;
            val       <= 1'b0;
            gen_count <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            left      <= left_n;
            col_idx   <= idx_n;
            drain     <= drain_n;
            cmd_ready <= ready_n;
            ld_ready  <= ld_ready_n;
            col_sel   <= col_sel_n;
            enable    <= enable_n;
            scan      <= scan_n;
            scan_val  <= scan_val_n;
            write_enb <= write_n;
            row       <= row_n;
            val       <= val_n;
            gen_count <= gen_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_life_ctrl.sv
// Self-checking bench for life_ctrl: randomized commands checked against a
// cycle-counting reference model of the command behaviour.
module tb_life_ctrl;

    localparam int NCOLS = 8;
    localparam int CW    = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [CW-1:0]    cmd_count = '0;
    logic [2:0]       cmd_col = '0;
    logic [1:0]       cmd_row = '0;
    logic             cmd_val = 1'b0;
    logic             halt = 1'b0;
    logic [3:0]       ld_data = '0;
    logic             ld_valid = 1'b0;
    logic             ld_ready;
    logic [NCOLS-1:0] col_sel;
    logic             enable, scan, write_enb, val, done;
    logic [3:0]       scan_val;
    logic [1:0]       row;
    logic [15:0]      gen_count;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_gen  = 0;

    life_ctrl #(.NCOLS(NCOLS), .CW(CW)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_col(cmd_col), .cmd_row(cmd_row),
        .cmd_val(cmd_val), .halt(halt), .ld_data(ld_data), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .col_sel(col_sel), .enable(enable), .scan(scan),
        .scan_val(scan_val), .write_enb(write_enb), .row(row), .val(val),
        .gen_count(gen_count), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            assert ($countones({enable, scan, write_enb}) <= 1)
                else $error("FAIL exclusivity: enable=%0b scan=%0b write_enb=%0b", enable, scan, write_enb);
        end
    end

    function automatic logic [36:0] out_vec();
        return {cmd_ready, ld_ready, col_sel, enable, scan, scan_val, write_enb, row, val, gen_count, done};
    endfunction

    // Waits for cmd_ready, offers one command, and returns at the negedge of
    // the first cycle after acceptance.
    task automatic issue(input logic [1:0] op, input int count, input int col, input int r, input logic v);
        int w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL issue_ready: cmd_ready=%0b after %0d cycles, want 1", cmd_ready, w);
        else n_pass++;
        cmd_valid = 1'b1; cmd_op = op; cmd_count = CW'(count);
        cmd_col = 3'(col); cmd_row = 2'(r); cmd_val = v;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Records one command's activity from cycle 1 until done (bounded).
    task automatic observe(input int max_cyc, input int halt_at,
                           output int en_cnt, output int en_first, output int en_last,
                           output int done_cyc, output int done_cnt,
                           output bit ready_busy, output bit ready_after, output int we_cnt);
        en_cnt = 0; en_first = -1; en_last = -1; done_cyc = -1; done_cnt = 0;
        ready_busy = 1'b0; ready_after = 1'b0; we_cnt = 0;
        for (int k = 1; k <= max_cyc; k++) begin
            if (enable) begin
                en_cnt++;
                if (en_first < 0) en_first = k;
                en_last = k;
            end
            if (write_enb) we_cnt++;
            if (cmd_ready) ready_busy = 1'b1;
            if (done) begin
                done_cnt++;
                done_cyc = k;
                halt = 1'b0;
                cmd_valid = 1'b0;
                @(negedge clk);
                ready_after = cmd_ready;
                if (done) done_cnt++;
                break;
            end
            if (k == halt_at) halt = 1'b1;
            @(negedge clk);
        end
        halt = 1'b0;
    endtask

    task automatic run_step(input string name, input int count, input int halt_at);
        int en_cnt, en_first, en_last, done_cyc, done_cnt, we_cnt, exp_en;
        bit rb, ra;
        exp_en = (halt_at > 0 && halt_at < count) ? halt_at : count;
        issue(2'b00, count, 0, 0, 1'b0);
        observe(count + 20, halt_at, en_cnt, en_first, en_last, done_cyc, done_cnt, rb, ra, we_cnt);
        exp_gen = (exp_gen + exp_en) & 16'hFFFF;
        n_checks++;
        if (en_cnt !== exp_en || (exp_en > 0 && (en_first !== 1 || en_last !== exp_en)))
            $display("FAIL %s_enable: cycles=%0d first=%0d last=%0d, want %0d from cycle 1", name, en_cnt, en_first, en_last, exp_en);
        else n_pass++;
        n_checks++;
        if (done_cnt !== 1 || done_cyc !== exp_en + 1)
            $display("FAIL %s_done: pulses=%0d at cycle %0d, want 1 at cycle %0d", name, done_cnt, done_cyc, exp_en + 1);
        else n_pass++;
        n_checks++;
        if (rb !== 1'b0 || ra !== 1'b1)
            $display("FAIL %s_ready: busy_high=%0b after=%0b, want 0/1", name, rb, ra);
        else n_pass++;
        n_checks++;
        if (gen_count !== 16'(exp_gen))
            $display("FAIL %s_gen: gen_count=%0h, want %0h", name, gen_count, exp_gen);
        else n_pass++;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        exp_gen = 0;
        n_checks++;
        if (out_vec() !== {1'b1, 36'b0}) $display("FAIL reset_outputs: got %h, want %h", out_vec(), {1'b1, 36'b0});
        else n_pass++;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        n_checks++;
        if (out_vec() !== {1'b1, 36'b0}) $display("FAIL reset_idle: got %h, want %h", out_vec(), {1'b1, 36'b0});
        else n_pass++;
    endtask

    task automatic test_step();
        int c, h;
        run_step("step5", 5, 0);
        run_step("step0", 0, 0);
        for (int i = 0; i < 4; i++) begin
            c = $urandom_range(1, 40);
            h = ($urandom_range(0, 1) == 1) ? $urandom_range(1, c) : 0;
            run_step("step_rand", c, h);
        end
    endtask

    task automatic test_halt();
        int en_cnt, en_first, en_last, done_cyc, done_cnt, we_cnt;
        int g0;
        bit rb, ra;
        g0 = int'(gen_count);
        issue(2'b00, 200, 0, 0, 1'b0);
        observe(220, 10, en_cnt, en_first, en_last, done_cyc, done_cnt, rb, ra, we_cnt);
        exp_gen = (exp_gen + en_cnt) & 16'hFFFF;
        n_checks++;
        if (!(en_cnt == 10 || en_cnt == 11) || en_last - en_first + 1 != en_cnt)
            $display("FAIL halt_enable: cycles=%0d first=%0d last=%0d, want 10 or 11 consecutive", en_cnt, en_first, en_last);
        else n_pass++;
        n_checks++;
        if (((int'(gen_count) - g0) & 16'hFFFF) !== en_cnt || done_cnt !== 1)
            $display("FAIL halt_gen: delta=%0d done=%0d, want %0d and 1", (int'(gen_count) - g0) & 16'hFFFF, done_cnt, en_cnt);
        else n_pass++;
    endtask

    task automatic run_load(input string name, input bit rand_stall);
        int scans = 0, done_k = -1, beats = 0;
        bit prev_beat = 1'b0, drive_v = 1'b0;
        logic [3:0] prev_data = '0;
        logic [NCOLS-1:0] one_col;
        logic [13:0] exp_v;
        issue(2'b01, 0, 0, 0, 1'b0);
        for (int k = 1; k <= 80; k++) begin
            if (prev_beat) begin
                one_col = NCOLS'(1) << scans;
                exp_v = {1'b1, prev_data, one_col, 1'b0};
                n_checks++;
                if ({scan, scan_val, col_sel, enable} !== exp_v)
                    $display("FAIL %s_pulse%0d: scan/val/col_sel/en=%h, want %h", name, scans, {scan, scan_val, col_sel, enable}, exp_v);
                else n_pass++;
                scans++;
            end else if (scan !== 1'b0 || col_sel !== '0) begin
                n_checks++;
                $display("FAIL %s_stall: cycle %0d scan=%0b col_sel=%h, want 0/0", name, k, scan, col_sel);
            end
            if (done) begin
                done_k = k;
                break;
            end
            drive_v = rand_stall ? 1'($urandom_range(0, 1)) : ~drive_v;
            ld_valid = drive_v;
            ld_data = 4'($urandom);
            prev_beat = ld_ready && ld_valid;
            prev_data = ld_data;
            if (prev_beat) beats++;
            @(negedge clk);
        end
        ld_valid = 1'b0;
        n_checks++;
        if (done_k < 0 || scans !== NCOLS || beats !== NCOLS)
            $display("FAIL %s_end: done_cycle=%0d scans=%0d beats=%0d, want done after %0d", name, done_k, scans, beats, NCOLS);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({done, ld_ready, scan, cmd_ready} !== 4'b0001)
            $display("FAIL %s_after: done/ld_ready/scan/ready=%b, want 0001", name, {done, ld_ready, scan, cmd_ready});
        else n_pass++;
    endtask

    task automatic test_load();
        run_load("load_toggle", 1'b0);
        run_load("load_rand", 1'b1);
    endtask

    task automatic do_write(input int col, input int r, input logic v);
        logic [NCOLS-1:0] exp_cols;
        exp_cols = NCOLS'(1) << col;
        issue(2'b10, 0, col, r, v);
        n_checks++;
        if ({write_enb, col_sel, row, val, enable, scan} !== {1'b1, exp_cols, 2'(r), v, 2'b00})
            $display("FAIL write_c%0d: we/col_sel/row/val/en/scan=%h, want %h", col,
                     {write_enb, col_sel, row, val, enable, scan}, {1'b1, exp_cols, 2'(r), v, 2'b00});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({done, write_enb, col_sel, row, val} !== {2'b10, 8'h00, 3'b000})
            $display("FAIL write_done_c%0d: done/we/col_sel/row/val=%h, want %h", col,
                     {done, write_enb, col_sel, row, val}, {2'b10, 8'h00, 3'b000});
        else n_pass++;
    endtask

    task automatic test_write_clear();
        do_write(3, 2, 1'b1);
        for (int i = 0; i < 3; i++) do_write($urandom_range(0, NCOLS - 1), $urandom_range(0, 3), 1'($urandom));
        issue(2'b11, 0, 0, 0, 1'b0);
        n_checks++;
        if ({scan, scan_val, col_sel, write_enb, enable} !== {1'b1, 4'h0, 8'hFF, 2'b00})
            $display("FAIL clear: scan/val/col_sel/we/en=%h, want %h", {scan, scan_val, col_sel, write_enb, enable}, {1'b1, 4'h0, 8'hFF, 2'b00});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({done, scan, col_sel} !== {2'b10, 8'h00})
            $display("FAIL clear_done: done/scan/col_sel=%h, want %h", {done, scan, col_sel}, {2'b10, 8'h00});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int en_cnt, en_first, en_last, done_cyc, done_cnt, we_cnt;
        bit rb, ra, extra_we;
        issue(2'b00, 6, 0, 0, 1'b0);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_col = 3'd5; cmd_row = 2'd1; cmd_val = 1'b1;
        observe(30, 0, en_cnt, en_first, en_last, done_cyc, done_cnt, rb, ra, we_cnt);
        exp_gen = (exp_gen + 6) & 16'hFFFF;
        extra_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (write_enb) extra_we = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (we_cnt !== 0 || extra_we || rb !== 1'b0 || en_cnt !== 6)
            $display("FAIL backpressure: writes=%0d late_write=%0b busy_ready=%0b enables=%0d, want 0/0/0/6",
                     we_cnt, extra_we, rb, en_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit saw;
        issue(2'b00, 20, 0, 0, 1'b0);
        @(negedge clk); @(negedge clk);
        #2 reset = 1'b0;
        #1;
        exp_gen = 0;
        n_checks++;
        if (out_vec() !== {1'b1, 36'b0}) $display("FAIL reset_mid: got %h, want %h", out_vec(), {1'b1, 36'b0});
        else n_pass++;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (done || enable || !cmd_ready) saw = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (saw !== 1'b0 || gen_count !== 16'h0)
            $display("FAIL reset_mid_after: activity=%0b gen=%h, want 0/0000", saw, gen_count);
        else n_pass++;
    endtask

    task automatic test_wrap();
        run_step("preset", (16'hFFFE - exp_gen) & 16'hFFFF, 0);
        run_step("wrap", 3, 0);
        n_checks++;
        if (gen_count !== 16'h0001) $display("FAIL wrap_value: gen_count=%h, want 0001", gen_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_step();
        test_halt();
        test_load();
        test_write_clear();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
